// File: rtl/dnn_perf_monitor.sv
// dnn_perf_monitor: per-case accuracy statistics (sliding window, epoch and error counters).
// Optional feature: define PERF_L1_ERR_EN to build the per-case L1 error accumulator (l1_sum_o).
module dnn_perf_monitor #(
    parameter int P         = 1,
    parameter int WIN       = 100,
    parameter int EPOCH_LEN = 50000,
    parameter int CNT_W     = 32,
    parameter int ACT_W     = 32,
    parameter int FRAC_BITS = 21
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       stat_clr_i,
    input  logic                       out_valid_i,
    input  logic                       case_end_i,
    input  logic [P-1:0]               a_out_i,
    input  logic [P-1:0]               y_out_i,
    input  logic [ACT_W*P-1:0]         act_l_i,
    output logic                       case_done_o,
    output logic                       case_ok_o,
    output logic [$clog2(WIN+1)-1:0]   recent_cnt_o,
    output logic [$clog2(WIN+1)-1:0]   win_fill_o,
    output logic [CNT_W-1:0]           num_case_o,
    output logic [CNT_W-1:0]           total_err_o,
    output logic [15:0]                epoch_o,
    output logic                       epoch_done_o,
    output logic [ACT_W+7:0]           l1_sum_o
);
    localparam int CW = $clog2(WIN + 1);
    localparam int PW = $clog2(WIN);
    localparam int EW = (EPOCH_LEN > 1) ? $clog2(EPOCH_LEN) : 1;

    logic             err_acc_q, err_acc_d;
    logic [WIN-1:0]   win_q, win_d;
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]    recent_q, recent_d, fill_q, fill_d;
    logic [CNT_W-1:0] num_q, num_d, terr_q, terr_d;
    logic [15:0]      epoch_q, epoch_d;
    logic [EW-1:0]    idx_q, idx_d;
    logic             done_q, done_d, ok_q, ok_d, edone_q, edone_d;
    logic             mismatch, ok, evict, full;

    // A mismatch on the closing cycle still belongs to the closing case
    assign mismatch = out_valid_i & |(a_out_i ^ y_out_i);
    assign ok       = ~(err_acc_q | mismatch);
    assign evict    = win_q[wr_ptr_q];
    assign full     = fill_q == CW'(WIN);

    // Next-state for the sticky error, window and counters; stat_clr discards a coincident close
    always_comb begin
        err_acc_d = err_acc_q | mismatch;
        win_d     = win_q;
        wr_ptr_d  = wr_ptr_q;
        recent_d  = recent_q;
        fill_d    = fill_q;
        num_d     = num_q;
        terr_d    = terr_q;
        epoch_d   = epoch_q;
        idx_d     = idx_q;
        ok_d      = ok_q;
        done_d    = 1'b0;
        edone_d   = 1'b0;
        if (stat_clr_i) begin
            err_acc_d = 1'b0;
            win_d     = '0;
            wr_ptr_d  = '0;
            recent_d  = '0;
            fill_d    = '0;
            num_d     = '0;
            terr_d    = '0;
            epoch_d   = '0;
            idx_d     = '0;
            ok_d      = 1'b0;
        end else if (case_end_i) begin
            err_acc_d       = 1'b0;
            done_d          = 1'b1;
            ok_d            = ok;
            win_d[wr_ptr_q] = ok;
            wr_ptr_d        = (wr_ptr_q == PW'(WIN - 1)) ? '0 : wr_ptr_q + 1'b1;
            recent_d        = recent_q + CW'(ok) - CW'(full & evict);
            fill_d          = full ? fill_q : fill_q + 1'b1;
            num_d           = (&num_q) ? num_q : num_q + 1'b1;
            terr_d          = (&terr_q | ok) ? terr_q : terr_q + 1'b1;
            edone_d         = idx_q == EW'(EPOCH_LEN - 1);
            idx_d           = edone_d ? '0 : idx_q + 1'b1;
            epoch_d         = epoch_q + 16'(edone_d);
        end
    end

    // Statistics registers with asynchronous reset
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            err_acc_q <= 1'b0;
            win_q     <= '0;
            wr_ptr_q  <= '0;
            recent_q  <= '0;
            fill_q    <= '0;
            num_q     <= '0;
            terr_q    <= '0;
            epoch_q   <= '0;
            idx_q     <= '0;
            done_q    <= 1'b0;
            ok_q      <= 1'b0;
            edone_q   <= 1'b0;
        end else begin
            err_acc_q <= err_acc_d;
            win_q     <= win_d;
            wr_ptr_q  <= wr_ptr_d;
            recent_q  <= recent_d;
            fill_q    <= fill_d;
            num_q     <= num_d;
            terr_q    <= terr_d;
            epoch_q   <= epoch_d;
            idx_q     <= idx_d;
            done_q    <= done_d;
            ok_q      <= ok_d;
            edone_q   <= edone_d;
        end
    end

    assert property (@(posedge clk_i) disable iff (!rst_ni) recent_q <= fill_q);

    assign case_done_o  = done_q;
    assign case_ok_o    = ok_q;
    assign recent_cnt_o = recent_q;
    assign win_fill_o   = fill_q;
    assign num_case_o   = num_q;
    assign total_err_o  = terr_q;
    assign epoch_o      = epoch_q;
    assign epoch_done_o = edone_q;

`ifdef PERF_L1_ERR_EN
    localparam int SW = ACT_W + 8;

    logic signed [SW-1:0] l1_lanes;
    logic [SW-1:0]        l1_add, l1_tot, l1_acc_q, l1_acc_d, l1_sum_q, l1_sum_d;
    logic [SW:0]          l1_wide;

    function automatic logic signed [SW-1:0] l1_term(input logic y, input logic signed [ACT_W-1:0] a);
        return y ? (SW'(1) <<< FRAC_BITS) - SW'(a) : SW'(a);
    endfunction

    // Saturating per-case sum of |y - act_l| over all lanes and valid cycles
    always_comb begin
        l1_lanes = '0;
        for (int i = 0; i < P; i++)
            l1_lanes = l1_lanes + l1_term(y_out_i[i], act_l_i[i*ACT_W +: ACT_W]);
        l1_add   = out_valid_i ? l1_lanes : '0;
        l1_wide  = {l1_acc_q[SW-1], l1_acc_q} + {l1_add[SW-1], l1_add};
        l1_tot   = (l1_wide[SW] == l1_wide[SW-1]) ? l1_wide[SW-1:0]
                 : l1_wide[SW] ? {1'b1, {(SW-1){1'b0}}} : {1'b0, {(SW-1){1'b1}}};
        l1_acc_d = (stat_clr_i | case_end_i) ? '0 : l1_tot;
        l1_sum_d = stat_clr_i ? '0 : case_end_i ? l1_tot : l1_sum_q;
    end

    // L1 accumulator and latched per-case result
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            l1_acc_q <= '0;
            l1_sum_q <= '0;
        end else begin
            l1_acc_q <= l1_acc_d;
            l1_sum_q <= l1_sum_d;
        end
    end

    assign l1_sum_o = l1_sum_q;
`else
    logic unused_act;
    assign unused_act = ^act_l_i ^ FRAC_BITS[0];
    assign l1_sum_o   = '0;
`endif
endmodule
